regfile_scoreboard: RTL and testbench

//  Register file for the pipelined processor: NUMREGS x REGWIDTH storage, 2 read ports, 1 write port.

---
 rtl/regfile_scoreboard_if.sv | 38 +++
 rtl/regfile_scoreboard.sv | 64 ++++++
 tb/tb_regfile_scoreboard.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Purpose: operand read, write-back and issue signals between pipeline stages and the register file.
// Latency: carries signals only; read data and busy flags are combinational in the register file.
// Backpressure: none on the bus itself; stall is the only hold request back to hazard control.
interface regfile_scoreboard_if #(
  parameter int REGWIDTH = 16
);
  logic [2:0]          read1RegSel;
  logic [2:0]          read2RegSel;
  logic                read1En;
  logic                read2En;
  logic [REGWIDTH-1:0] read1Data;
  logic [REGWIDTH-1:0] read2Data;
  logic [2:0]          writeRegSel;
  logic [REGWIDTH-1:0] writeData;
  logic                writeEn;
  logic [2:0]          issueRegSel;
  logic                issueEn;
  logic                read1Busy;
  logic                read2Busy;
  logic                stall;
  logic                err;

  // Pipeline side: decode, write-back and hazard control
  modport master (
    output read1RegSel, read2RegSel, read1En, read2En,
    output writeRegSel, writeData, writeEn,
    output issueRegSel, issueEn,
    input  read1Data, read2Data, read1Busy, read2Busy, stall, err
  );

  // Register file side
  modport slave (
    input  read1RegSel, read2RegSel, read1En, read2En,
    input  writeRegSel, writeData, writeEn,
    input  issueRegSel, issueEn,
    output read1Data, read2Data, read1Busy, read2Busy, stall, err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Purpose: 8-entry register file with two bypassed read ports, one write port and a pending-producer scoreboard.
// Latency: reads, busy, stall and err are combinational; writes and pending bits update on the next posedge.
// Backpressure: raises stall when a used operand is pending with no same-cycle write to bypass; never blocks issue itself.
module regfile_scoreboard #(
  parameter int REGWIDTH = 16,
  parameter int NUMREGS  = 8
) (
  input logic               clk,
  input logic               rst_n,
  regfile_scoreboard_if.slave rf
);

  logic [REGWIDTH-1:0] regs [NUMREGS];
  logic [NUMREGS-1:0]  pend;
  logic [NUMREGS-1:0]  setVec;
  logic [NUMREGS-1:0]  clearVec;
  logic                read1Hit;
  logic                read2Hit;
  logic                issueHit;

  // A same-cycle write to the selected register forwards its data and retires the dependency
  always_comb begin
    read1Hit = rf.writeEn && (rf.writeRegSel == rf.read1RegSel);
    read2Hit = rf.writeEn && (rf.writeRegSel == rf.read2RegSel);
    issueHit = rf.writeEn && (rf.writeRegSel == rf.issueRegSel);
  end

  // Decode the issue and write-back destinations into per-register set/clear masks
  always_comb begin
    setVec   = '0;
    clearVec = '0;
    if (rf.issueEn) setVec[rf.issueRegSel] = 1'b1;
    if (rf.writeEn) clearVec[rf.writeRegSel] = 1'b1;
  end

  // Register storage; R0 is an ordinary writable register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUMREGS; i++) regs[i] <= '0;
    end else if (rf.writeEn) begin
      regs[rf.writeRegSel] <= rf.writeData;
    end
  end

  // Scoreboard: a new issue wins over a retiring write, since the newer producer owns the register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      pend <= setVec | (pend & ~clearVec);
    end
  end

  // Operand data, busy flags, stall and WAW error, all combinational
  always_comb begin
    rf.read1Data = read1Hit ? rf.writeData : regs[rf.read1RegSel];
    rf.read2Data = read2Hit ? rf.writeData : regs[rf.read2RegSel];
    rf.read1Busy = pend[rf.read1RegSel] && !read1Hit;
    rf.read2Busy = pend[rf.read2RegSel] && !read2Hit;
    rf.stall     = (rf.read1En && rf.read1Busy) || (rf.read2En && rf.read2Busy);
    rf.err       = rf.issueEn && pend[rf.issueRegSel] && !issueHit;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Purpose: directed self-checking bench for the register file and scoreboard.
// Latency: inputs driven 1ns after posedge, outputs sampled after a further settle delay.
// Backpressure: stall is observed and checked, not acted on.
module tb_regfile_scoreboard;

  logic clk;
  logic rst_n;
  int   assertCnt;
  int   failCnt;

  regfile_scoreboard_if #(.REGWIDTH(16)) rfIf ();

  regfile_scoreboard #(.REGWIDTH(16), .NUMREGS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (rfIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCnt++;
    if (obs !== exp) begin
      failCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rfIf.writeEn = 1'b0;
    rfIf.issueEn = 1'b0;
    rfIf.read1En = 1'b0;
    rfIf.read2En = 1'b0;
  endtask

  initial begin
    assertCnt = 0;
    failCnt   = 0;
    rst_n     = 1'b0;
    rfIf.read1RegSel = 3'd3;
    rfIf.read2RegSel = 3'd7;
    rfIf.writeRegSel = 3'd0;
    rfIf.writeData   = 16'h0;
    rfIf.issueRegSel = 3'd0;
    idle();

    // Reset state, during and after reset
    #12;
    checkVal("rst_rd1", rfIf.read1Data, 32'h0);
    checkVal("rst_rd2", rfIf.read2Data, 32'h0);
    checkVal("rst_busy1", rfIf.read1Busy, 32'h0);
    checkVal("rst_busy2", rfIf.read2Busy, 32'h0);
    checkVal("rst_stall", rfIf.stall, 32'h0);
    checkVal("rst_err", rfIf.err, 32'h0);
    #1 rst_n = 1'b1;
    tick();
    checkVal("post_rst_rd1", rfIf.read1Data, 32'h0);
    checkVal("post_rst_stall", rfIf.stall, 32'h0);

    // Write R5 then read it back next cycle
    rfIf.writeEn = 1'b1; rfIf.writeRegSel = 3'd5; rfIf.writeData = 16'hBEEF;
    tick();
    idle();
    rfIf.read1RegSel = 3'd5; rfIf.read2RegSel = 3'd4;
    #1;
    checkVal("wr_rd_r5", rfIf.read1Data, 32'hBEEF);
    checkVal("wr_rd_r4", rfIf.read2Data, 32'h0);

    // Both ports bypass the same write
    rfIf.writeEn = 1'b1; rfIf.writeRegSel = 3'd2; rfIf.writeData = 16'h1234;
    rfIf.read1RegSel = 3'd2; rfIf.read2RegSel = 3'd2;
    #1;
    checkVal("byp_rd1", rfIf.read1Data, 32'h1234);
    checkVal("byp_rd2", rfIf.read2Data, 32'h1234);
    tick();
    idle();
    #1;
    checkVal("byp_stored", rfIf.read1Data, 32'h1234);

    // Issue R3: busy only from the next cycle
    rfIf.issueEn = 1'b1; rfIf.issueRegSel = 3'd3;
    rfIf.read1RegSel = 3'd3; rfIf.read1En = 1'b1;
    #1;
    checkVal("iss_same_busy1", rfIf.read1Busy, 32'h0);
    checkVal("iss_same_err", rfIf.err, 32'h0);
    tick();
    rfIf.issueEn = 1'b0;
    #1;
    checkVal("sb_busy1", rfIf.read1Busy, 32'h1);
    checkVal("sb_stall", rfIf.stall, 32'h1);
    // Unused operand must not stall
    rfIf.read1En = 1'b0; rfIf.read2RegSel = 3'd3; rfIf.read2En = 1'b0;
    #1;
    checkVal("sb_busy2_unused", rfIf.read2Busy, 32'h1);
    checkVal("sb_stall_gated", rfIf.stall, 32'h0);
    rfIf.read2En = 1'b1;
    #1;
    checkVal("sb_stall_port2", rfIf.stall, 32'h1);
    rfIf.read2En = 1'b0; rfIf.read1En = 1'b1;
    // Write-back R3 resolves the dependency in the same cycle
    rfIf.writeEn = 1'b1; rfIf.writeRegSel = 3'd3; rfIf.writeData = 16'h00AA;
    #1;
    checkVal("wb_busy1", rfIf.read1Busy, 32'h0);
    checkVal("wb_stall", rfIf.stall, 32'h0);
    checkVal("wb_rd1", rfIf.read1Data, 32'h00AA);
    tick();
    rfIf.writeEn = 1'b0;
    #1;
    checkVal("wb_pend_clear", rfIf.read1Busy, 32'h0);
    checkVal("wb_stall_after", rfIf.stall, 32'h0);
    checkVal("wb_rd1_after", rfIf.read1Data, 32'h00AA);
    idle();

    // Set wins over clear; WAW with a covering write is not an error
    rfIf.issueEn = 1'b1; rfIf.issueRegSel = 3'd6;
    tick();
    rfIf.writeEn = 1'b1; rfIf.writeRegSel = 3'd6; rfIf.writeData = 16'h0066;
    #1;
    checkVal("waw_cov_err", rfIf.err, 32'h0);
    tick();
    idle();
    rfIf.read1RegSel = 3'd6;
    #1;
    checkVal("set_wins_busy", rfIf.read1Busy, 32'h1);
    checkVal("set_wins_data", rfIf.read1Data, 32'h0066);
    rfIf.issueEn = 1'b1; rfIf.issueRegSel = 3'd6;
    #1;
    checkVal("waw_err", rfIf.err, 32'h1);
    tick();
    rfIf.issueEn = 1'b0;
    #1;
    checkVal("waw_err_clear", rfIf.err, 32'h0);
    checkVal("waw_still_pend", rfIf.read1Busy, 32'h1);

    // Async reset mid-operation: R1 holds 0x5555 and is pending
    rfIf.writeEn = 1'b1; rfIf.writeRegSel = 3'd1; rfIf.writeData = 16'h5555;
    tick();
    rfIf.writeEn = 1'b0;
    rfIf.issueEn = 1'b1; rfIf.issueRegSel = 3'd1;
    tick();
    rfIf.issueEn = 1'b0;
    rfIf.read1RegSel = 3'd1; rfIf.read2RegSel = 3'd6;
    #1;
    checkVal("pre_arst_busy1", rfIf.read1Busy, 32'h1);
    checkVal("pre_arst_rd1", rfIf.read1Data, 32'h5555);
    #1 rst_n = 1'b0;
    #1;
    checkVal("arst_busy1", rfIf.read1Busy, 32'h0);
    checkVal("arst_rd1", rfIf.read1Data, 32'h0);
    checkVal("arst_busy2", rfIf.read2Busy, 32'h0);
    // Write and issue while held in reset are discarded
    rfIf.writeEn = 1'b1; rfIf.writeRegSel = 3'd4; rfIf.writeData = 16'h4444;
    rfIf.issueEn = 1'b1; rfIf.issueRegSel = 3'd4;
    tick();
    idle();
    #1 rst_n = 1'b1;
    rfIf.read2RegSel = 3'd4;
    #1;
    checkVal("arst_drop_wr", rfIf.read2Data, 32'h0);
    checkVal("arst_drop_iss", rfIf.read2Busy, 32'h0);
    rfIf.read1RegSel = 3'd5;
    #1;
    checkVal("arst_r5_clear", rfIf.read1Data, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
